// File: rtl/alu_uart_sequencer_if.sv
// Bus bundle between alu_uart_sequencer and its environment (UART rx/tx
// and the combinational ALU). The sequencer uses the slave modport; the
// environment (testbench or top level) uses the master modport.
interface alu_uart_sequencer_if #(
  parameter int N_BITS = 32,
  parameter int N_OP   = 6,
  parameter int N_BYTE = 8
);
  logic [N_BYTE-1:0] i_rx_data;
  logic              i_rx_done;
  logic              i_tx_done;
  logic [N_BITS-1:0] i_alu_result;
  logic [N_BITS-1:0] o_alu_a;
  logic [N_BITS-1:0] o_alu_b;
  logic [N_OP-1:0]   o_alu_op;
  logic [N_BYTE-1:0] o_tx_data;
  logic              o_tx_start;
  logic              o_busy;
  logic              o_op_err;

  modport master (
    output i_rx_data, i_rx_done, i_tx_done, i_alu_result,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_op_err
  );

  modport slave (
    input  i_rx_data, i_rx_done, i_tx_done, i_alu_result,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_op_err
  );
endinterface

// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer: byte-serial front end for the combinational ALU.
// Loads operand A, operand B (LSB byte first) and a function code from the
// UART receive stream, runs the ALU for one cycle, then streams the result
// back through the UART transmitter one byte at a time.
// Optional build macro ALU_OP_CHECK_EN: rejects unsupported function codes
// with a one-cycle o_op_err pulse and a single 0xEE reply byte.
module alu_uart_sequencer #(
  parameter int N_BITS = 32,
  parameter int N_OP   = 6,
  parameter int N_BYTE = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  alu_uart_sequencer_if.slave bus
);

  localparam int NB    = N_BITS / N_BYTE;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NB - 1);
  localparam logic [N_BYTE-1:0] ERR_BYTE = N_BYTE'(8'hEE);

  typedef enum logic [2:0] {
    LOAD_A   = 3'd0,
    LOAD_B   = 3'd1,
    LOAD_OP  = 3'd2,
    EXEC     = 3'd3,
    TX_START = 3'd4,
    TX_WAIT  = 3'd5
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;
  logic              idx_last;
  logic [N_BITS-1:0] result;
  logic              err_flag;
  logic              op_miss;

  logic              load_a;
  logic              load_b;
  logic              load_op;
  logic              latch_res;
  logic              tx_start_d;
  logic              busy_d;
  logic [N_BYTE-1:0] tx_data_d;

  // Replace one byte lane of a word.
  function automatic logic [N_BITS-1:0] put_lane(input logic [N_BITS-1:0] w,
                                                 input logic [IDX_W-1:0]  sel,
                                                 input logic [N_BYTE-1:0] b);
    logic [N_BITS-1:0] r;
    r = w;
    r[sel*N_BYTE +: N_BYTE] = b;
    return r;
  endfunction

  // Extract one byte lane of a word.
  function automatic logic [N_BYTE-1:0] get_lane(input logic [N_BITS-1:0] w,
                                                 input logic [IDX_W-1:0]  sel);
    return w[sel*N_BYTE +: N_BYTE];
  endfunction

`ifdef ALU_OP_CHECK_EN
  // Function codes the ALU actually implements.
  function automatic logic op_supported(input logic [N_OP-1:0] op);
    logic ok;
    case (op)
      N_OP'('h20), N_OP'('h22), N_OP'('h24), N_OP'('h25),
      N_OP'('h26), N_OP'('h03), N_OP'('h02), N_OP'('h27): ok = 1'b1;
      default:                                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign op_miss = !op_supported(bus.o_alu_op);
`else
  assign op_miss = 1'b0;
`endif

  assign idx_last = (idx == IDX_LAST);

  // State register and byte index
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= LOAD_A;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next-state and byte-index logic
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      LOAD_A: begin
        if (bus.i_rx_done) begin
          if (idx_last) begin
            state_next = LOAD_B;
            idx_next   = '0;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (bus.i_rx_done) begin
          if (idx_last) begin
            state_next = LOAD_OP;
            idx_next   = '0;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      LOAD_OP: begin
        if (bus.i_rx_done) state_next = EXEC;
      end
      EXEC: begin
        state_next = TX_START;
      end
      TX_START: begin
        state_next = TX_WAIT;
      end
      TX_WAIT: begin
        if (bus.i_tx_done) begin
          // A rejected op replies with a single byte, so it also ends here.
          if (idx_last || err_flag) begin
            state_next = LOAD_A;
            idx_next   = '0;
          end else begin
            state_next = TX_START;
            idx_next   = idx + 1'b1;
          end
        end
      end
      default: begin
        state_next = LOAD_A;
        idx_next   = '0;
      end
    endcase
  end

  // Output decode: register enables and next values of registered outputs
  always_comb begin
    load_a     = (state == LOAD_A)  && bus.i_rx_done;
    load_b     = (state == LOAD_B)  && bus.i_rx_done;
    load_op    = (state == LOAD_OP) && bus.i_rx_done;
    latch_res  = (state == EXEC)    && !op_miss;
    tx_start_d = (state_next == TX_START);
    busy_d     = (state_next == EXEC) || (state_next == TX_START) ||
                 (state_next == TX_WAIT);
    tx_data_d  = bus.o_tx_data;
    if (state_next == TX_START) begin
      // Leaving EXEC the result register is being written on this same edge,
      // so the first byte is taken straight from the ALU.
      if (state == EXEC) begin
        tx_data_d = op_miss ? ERR_BYTE : get_lane(bus.i_alu_result, idx_next);
      end else begin
        tx_data_d = get_lane(result, idx_next);
      end
    end
  end

  // Operand, op, result and transmit-side registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bus.o_alu_a    <= '0;
      bus.o_alu_b    <= '0;
      bus.o_alu_op   <= '0;
      bus.o_tx_data  <= '0;
      bus.o_tx_start <= 1'b0;
      bus.o_busy     <= 1'b0;
      result         <= '0;
      err_flag       <= 1'b0;
    end else begin
      if (load_a)  bus.o_alu_a  <= put_lane(bus.o_alu_a, idx, bus.i_rx_data);
      if (load_b)  bus.o_alu_b  <= put_lane(bus.o_alu_b, idx, bus.i_rx_data);
      if (load_op) bus.o_alu_op <= bus.i_rx_data[N_OP-1:0];
      if (latch_res) result <= bus.i_alu_result;
      if (state == EXEC) err_flag <= op_miss;
      bus.o_tx_data  <= tx_data_d;
      bus.o_tx_start <= tx_start_d;
      bus.o_busy     <= busy_d;
    end
  end

`ifdef ALU_OP_CHECK_EN
  // Rejected-op pulse, coincident with the 0xEE transmit start
  always_ff @(posedge i_clk) begin
    if (i_reset) bus.o_op_err <= 1'b0;
    else         bus.o_op_err <= (state == EXEC) && op_miss;
  end
`else
  assign bus.o_op_err = 1'b0;
`endif

endmodule

// File: doc/alu_uart_sequencer.md
Name: alu_uart_sequencer

Overview:
Byte-serial front end that drives the combinational ALU from a UART link.
- Collects operand A, operand B and the 6-bit function code from the UART receiver's byte stream, and holds them on registered outputs wired to the ALU inputs.
- Captures the ALU result and streams it back to the UART transmitter, one byte at a time.
- Sits between uart_rx/uart_tx and the ALU in the top-level ALU test/debug path.

Parameters:
N_BITS, 32, ALU data width; must be a multiple of 8.
N_OP, 6, ALU function-code width.
N_BYTE, 8, UART byte width.

Ports:
i_clk  in  1  system clock; all state changes on rising edge.
i_reset  in  1  synchronous, active-high reset.
i_rx_data  in  N_BYTE  received byte; valid only when i_rx_done=1.
i_rx_done  in  1  one-cycle strobe, new byte on i_rx_data.
i_tx_done  in  1  one-cycle strobe, transmitter finished the current byte.
i_alu_result  in  N_BITS  ALU output.
o_alu_a  out  N_BITS  operand A register, drives ALU input a.
o_alu_b  out  N_BITS  operand B register, drives ALU input b.
o_alu_op  out  N_OP  function-code register, drives ALU op input.
o_tx_data  out  N_BYTE  byte to transmit; held stable from o_tx_start until i_tx_done.
o_tx_start  out  1  registered one-cycle pulse; starts the transmitter.
o_busy  out  1  1 in EXEC, TX_START and TX_WAIT states.
o_op_err  out  1  one-cycle pulse on a rejected op; tied 0 without the macro.

Behaviour:
- Reset values (synchronous, i_reset=1 at an edge):
  - state=LOAD_A, byte index=0.
  - o_alu_a, o_alu_b, o_alu_op, o_tx_data, the result register, o_tx_start, o_busy and o_op_err all =0.
  - Reset overrides every other event and aborts any transaction in progress; a partially loaded operand keeps no special meaning.
- Byte count: NB = N_BITS/8. The byte index counter is clog2(NB) bits wide (minimum 1 bit) and wraps to 0 after NB-1.
- LOAD_A:
  - On each i_rx_done, write i_rx_data into byte lane [idx] of o_alu_a (LSB first) and increment idx.
  - On the strobe with idx=NB-1, go to LOAD_B with idx=0.
- LOAD_B: identical to LOAD_A, writing o_alu_b; after its last byte, go to LOAD_OP.
- LOAD_OP:
  - On i_rx_done, o_alu_op <= i_rx_data[N_OP-1:0]; the upper bits are ignored.
  - Go to EXEC.
- EXEC (exactly one cycle):
  - Latch i_alu_result into the result register; operands are stable for the whole cycle.
  - Go to TX_START.
- TX_START (exactly one cycle):
  - o_tx_start=1 and o_tx_data=result byte [idx].
  - Go to TX_WAIT; an i_tx_done arriving in this state is ignored.
- TX_WAIT:
  - Hold o_tx_data until i_tx_done.
  - On i_tx_done: if idx=NB-1, go to LOAD_A with idx=0; otherwise idx+1 and go to TX_START.
- Latency: with the op-byte strobe sampled at edge T, o_tx_start is high in the cycle following edge T+1.
- i_rx_done in EXEC, TX_START or TX_WAIT: the byte is dropped and no register changes (no queuing).
- i_tx_done outside TX_WAIT: ignored.
- ALU operand/op outputs keep their values after a transaction; they are overwritten byte-by-byte by the next one.

Optional Feature:
Macro ALU_OP_CHECK_EN.
- Defined:
  - In EXEC, o_alu_op is checked against the supported set {0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x03 SRA, 0x02 SRL, 0x27 NOR}.
  - On a miss: o_op_err pulses for one cycle, the result is not latched, and a single byte 0xEE is sent through TX_START/TX_WAIT.
  - After i_tx_done the block returns to LOAD_A.
- Undefined: no check; every op executes and o_op_err is constant 0.

Test Plan:
1. ADD: rx 05 00 00 00, 03 00 00 00, 20 -> o_alu_a=5, o_alu_b=3, o_alu_op=0x20; tx bytes 08 00 00 00 in order; one o_tx_start per i_tx_done.
2. SUB with borrow: A=3, B=5, op 22 -> tx FE FF FF FF; o_tx_start first high in the cycle after edge T+1 relative to the op strobe at edge T.
3. NOR plus op masking: A=0, B=0, op byte 0xE7 -> o_alu_op=0x27; tx FF FF FF FF.
4. Reset mid-load: two A bytes, then i_reset=1 for one cycle -> all outputs 0 and state LOAD_A; a following full ADD 1+1 returns 02 00 00 00.
5. Rx during transmit: inject i_rx_done with 0xAA while in TX_WAIT -> ignored; o_alu_a unchanged; the next transaction loads correctly from byte 0.
6. ALU_OP_CHECK_EN defined: op 0x3F -> o_op_err one-cycle pulse; exactly one tx byte 0xEE; return to LOAD_A. Macro undefined: same stimulus sends 4 bytes and o_op_err stays 0.
